regwb: RTL and testbench
========================

# regwb

Write-back arbiter and queue that owns the single write port of the 32×32 register file. It accepts results from two producers over valid/ready handshakes:
- src0: ALU result path.
- src1: memory-load / multi-cycle unit path.

It round-robins between them, buffers accepted results in a small FIFO while the port is held, and retires them in acceptance order onto `we`/`wreg`/`wdata`. It also exports a pending-write bitmask that the decode stage uses for hazard stalls.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s0_valid  in  1  src0 has a result.
- s0_ready  out  1  src0 result accepted this cycle.
- s0_reg  in  5  src0 destination register.
- s0_data  in  32  src0 result.
- s1_valid, s1_ready, s1_reg, s1_data  same as src0, for src1.
- hold  in  1  register-file port unavailable this cycle (debug/exception writer owns it).
- we  out  1  register-file write enable, registered.
- wreg  out  5  register-file write index, registered.
- wdata  out  32  register-file write data, registered.
- pend  out  32  bit r=1 while a write to register r is queued or on the output stage.
- count  out  $clog2(DEPTH+1)  FIFO occupancy, excluding the output stage.

## Operation
- **Arbitration** (combinational):
  - At most one source is granted per cycle.
  - If exactly one valid is high, that source is granted.
  - If both are high, the source selected by the round-robin bit `rr` is granted (rr=0 → src0). `rr` flips to the other source only after a contended grant.
  - `sX_ready` = granted AND (count < DEPTH). Ready is 0 when the FIFO is full, even if a pop happens that cycle.
- **Register 0**: an accepted result with reg=0 completes the handshake but is discarded. No entry is created, no `we` is produced, `pend` is unchanged.
- **Output stage**: each edge with hold=0:
  - If the FIFO is non-empty, pop the head into we=1/wreg/wdata.
  - Else, if an accepted non-zero result exists this cycle, bypass it directly into the output stage.
  - Else, we=0 (wreg/wdata keep their last values).
- **Push**: an accepted non-zero result enters the FIFO when it is not bypassed, i.e. FIFO non-empty or hold=1.
- **Hold**: an edge with hold=1 loads we=0, performs no pop and no bypass; pushes continue.
- **Ordering**: writes retire strictly in acceptance order, including multiple writes to the same register.
- **pend**: combinational OR over all valid FIFO entries plus the output stage when we=1. pend[0] is always 0.

## Timing
- Reset values: we=0, wreg=0, wdata=0, pend=0, count=0, rr=0, FIFO empty. Reset is applied asynchronously, mid-transfer included; all queued writes are lost.
- **Latency**: handshake in cycle N with the FIFO empty and hold=0 → we=1 in cycle N+1. With k entries ahead and no hold → we in cycle N+1+k.
- **Throughput**: one retirement per cycle while hold=0.
- **Simultaneous push and pop**: allowed; count is unchanged.
- **Pointer wrap**: pointers wrap modulo DEPTH. Full/empty are distinguished by count.
- **pend for a result accepted in cycle N**:
  - Rises in cycle N+1.
  - Falls in the cycle after its we=1 cycle, unless another queued write targets the same register.

## Test plan
- **Reset**: assert rst_n=0 asynchronously mid-cycle with 3 entries queued → we=0, pend=0, count=0 immediately. After release: s0_ready=1 when s0_valid=1.
- **Single write**: s0 writes r5=0x0000_1234 in cycle N → we=1, wreg=5, wdata=0x1234 in N+1. pend[5]=1 in N+1 and 0 in N+2.
- **Contention**: s0_valid=s1_valid=1 held for 6 cycles with distinct regs → grants src0, src1, src0, src1, src0, src1; writes appear in that order, one per cycle, starting one cycle later.
- **Hold/full**: hold=1 for 6 cycles while s0 offers r1..r6 → r1..r4 accepted, count=4, s0_ready=0 afterwards, pend[4:1]=1. Release hold → r1..r4 retire on 4 consecutive cycles, then r5, r6.
- **r0 discard**: s1 writes r0=0xFFFF_FFFF → s1_ready=1, we stays 0, pend=0.
- **Same-register ordering**: s0 writes r7=1 then s1 writes r7=2 during hold. Release → we shows r7=1, then r7=2. pend[7] stays 1 until after the second write.

Source files
------------

// File: rtl/regwb.sv
// Write-back arbiter and in-order queue feeding the single register-file write port.
// Two producers round-robin into a small FIFO; the head (or a bypassed result) drives we/wreg/wdata.
module regwb #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s0_valid,
    output logic                       s0_ready,
    input  logic [4:0]                 s0_reg,
    input  logic [31:0]                s0_data,
    input  logic                       s1_valid,
    output logic                       s1_ready,
    input  logic [4:0]                 s1_reg,
    input  logic [31:0]                s1_data,
    input  logic                       hold,
    output logic                       we,
    output logic [4:0]                 wreg,
    output logic [31:0]                wdata,
    output logic [31:0]                pend,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    // DEPTH must be a power of two so the pointers wrap for free.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Handshake: a result transfers on a cycle where sX_valid and sX_ready are both high;
    // the producer keeps valid/reg/data stable until that cycle.

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } wb_t;

    wb_t            mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [CW-1:0]  cnt;
    logic           rr;

    logic           grant0;
    logic           grant1;
    logic           not_full;
    logic           fifo_empty;
    logic           acc;
    logic           acc_live;
    logic           contended;
    wb_t            acc_ent;
    logic           pop;
    logic           push;
    logic           bypass;

    logic [31:0]    pend_c;
    logic [AW-1:0]  slot_off;

    // Arbitration and datapath steering
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (s0_valid && s1_valid) begin
            grant0 = !rr;
            grant1 = rr;
        end else begin
            grant0 = s0_valid;
            grant1 = s1_valid;
        end

        not_full   = (cnt < CW'(DEPTH));
        fifo_empty = (cnt == '0);

        s0_ready = grant0 && not_full;
        s1_ready = grant1 && not_full;

        acc       = s0_ready || s1_ready;
        acc_ent   = s1_ready ? wb_t'{idx: s1_reg, data: s1_data}
                             : wb_t'{idx: s0_reg, data: s0_data};
        // Writes to r0 finish the handshake but never touch the queue.
        acc_live  = acc && (acc_ent.idx != 5'd0);
        // rr only moves when a contended offer actually transfers, so a stalled loser keeps priority.
        contended = s0_valid && s1_valid && acc;

        pop    = !hold && !fifo_empty;
        bypass = !hold && fifo_empty && acc_live;
        push   = acc_live && !bypass;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            rr     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (contended) begin
                rr <= !rr;
            end
        end
    end

    // Storage is not reset: occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= acc_ent;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we    <= 1'b0;
            wreg  <= '0;
            wdata <= '0;
        end else if (hold) begin
            we <= 1'b0;
        end else if (pop) begin
            we    <= 1'b1;
            wreg  <= mem[rd_ptr].idx;
            wdata <= mem[rd_ptr].data;
        end else if (bypass) begin
            we    <= 1'b1;
            wreg  <= acc_ent.idx;
            wdata <= acc_ent.data;
        end else begin
            we <= 1'b0;
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        pend_c   = '0;
        slot_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = AW'(i) - rd_ptr;
            if (CW'(slot_off) < cnt) begin
                pend_c[mem[i].idx] = 1'b1;
            end
        end
        if (we) begin
            pend_c[wreg] = 1'b1;
        end
        pend_c[0] = 1'b0;
    end

    assign pend  = pend_c;
    assign count = cnt;

endmodule

// File: tb/tb_regwb.sv
// Bench for regwb: table of per-cycle offers with expected ready, plus a queue model
// that predicts we/wreg/wdata, pend and count every cycle.
module tb_regwb;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s0_valid, s1_valid, hold;
    logic          s0_ready, s1_ready;
    logic [4:0]    s0_reg, s1_reg, wreg;
    logic [31:0]   s0_data, s1_data, wdata, pend;
    logic          we;
    logic [CW-1:0] count;

    regwb #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s0_reg   (s0_reg),
        .s0_data  (s0_data),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .s1_reg   (s1_reg),
        .s1_data  (s1_data),
        .hold     (hold),
        .we       (we),
        .wreg     (wreg),
        .wdata    (wdata),
        .pend     (pend),
        .count    (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s0v;
        logic [4:0]  s0r;
        logic [31:0] s0d;
        logic        s1v;
        logic [4:0]  s1r;
        logic [31:0] s1d;
        logic        hold;
        logic        e0;
        logic        e1;
    } vec_t;

    vec_t        tbl[$];
    logic [36:0] exp_q[$];
    logic        model_we;
    logic [36:0] model_out;
    logic        rr_m;
    int          n_checks;
    int          n_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic s0v, input logic [4:0] s0r, input logic [31:0] s0d,
                                input logic s1v, input logic [4:0] s1r, input logic [31:0] s1d,
                                input logic h, input logic e0, input logic e1);
        vec_t v;
        v.s0v = s0v; v.s0r = s0r; v.s0d = s0d;
        v.s1v = s1v; v.s1r = s1r; v.s1d = s1d;
        v.hold = h; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    function automatic logic [31:0] pend_model();
        logic [31:0] p;
        p = '0;
        foreach (exp_q[i]) p[exp_q[i][36:32]] = 1'b1;
        if (model_we) p[model_out[36:32]] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    // Called just after a rising edge: drive, check at the falling edge, advance the model.
    task automatic run_vec(input vec_t v);
        s0_valid = v.s0v; s0_reg = v.s0r; s0_data = v.s0d;
        s1_valid = v.s1v; s1_reg = v.s1r; s1_data = v.s1d;
        hold     = v.hold;
        @(negedge clk);
        chk("we", 64'(we), 64'(model_we));
        if (model_we) begin
            chk("wreg", 64'(wreg), 64'(model_out[36:32]));
            chk("wdata", 64'(wdata), 64'(model_out[31:0]));
        end
        chk("pend", 64'(pend), 64'(pend_model()));
        chk("count", 64'(count), 64'(exp_q.size()));
        chk("s0_ready", 64'(s0_ready), 64'(v.e0));
        chk("s1_ready", 64'(s1_ready), 64'(v.e1));
        if (v.e0 && v.s0r != 5'd0) exp_q.push_back({v.s0r, v.s0d});
        if (v.e1 && v.s1r != 5'd0) exp_q.push_back({v.s1r, v.s1d});
        if (v.s0v && v.s1v && (v.e0 || v.e1)) rr_m = !rr_m;
        if (v.hold) begin
            model_we = 1'b0;
        end else if (exp_q.size() > 0) begin
            model_out = exp_q.pop_front();
            model_we  = 1'b1;
        end else begin
            model_we = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        logic        o0v, o1v, h, g0, g1, nf;
        logic [4:0]  o0r, o1r;
        logic [31:0] o0d, o1d;
        vec_t        v;

        n_checks = 0; n_fail = 0;
        model_we = 1'b0; model_out = '0; rr_m = 1'b0;
        rst_n = 1'b0;
        s0_valid = 0; s0_reg = 0; s0_data = 0;
        s1_valid = 0; s1_reg = 0; s1_data = 0;
        hold = 0;

        // Clock/reset block
        repeat (2) @(posedge clk);
        #1;
        chk("reset_we", 64'(we), 64'(0));
        chk("reset_wreg", 64'(wreg), 64'(0));
        chk("reset_wdata", 64'(wdata), 64'(0));
        chk("reset_pend", 64'(pend), 64'(0));
        chk("reset_count", 64'(count), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cycle table
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 32'h0000_1234, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 10, 32'hA0, 1, 20, 32'hB0, 0, 1, 0));
        tbl.push_back(mk(1, 11, 32'hA1, 1, 20, 32'hB0, 0, 0, 1));
        tbl.push_back(mk(1, 11, 32'hA1, 1, 21, 32'hB1, 0, 1, 0));
        tbl.push_back(mk(1, 12, 32'hA2, 1, 21, 32'hB1, 0, 0, 1));
        tbl.push_back(mk(1, 12, 32'hA2, 1, 22, 32'hB2, 0, 1, 0));
        tbl.push_back(mk(1, 13, 32'hA3, 1, 22, 32'hB2, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'h101, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 2, 32'h102, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 3, 32'h103, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 4, 32'h104, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 5, 32'h105, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 5, 32'h105, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 5, 32'h105, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 32'h105, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 6, 32'h106, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 32'h1, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 7, 32'h2, 1, 0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // Random offers with sources that hold their offer until accepted
        o0v = 0; o1v = 0; o0r = 0; o1r = 0; o0d = 0; o1d = 0;
        for (int c = 0; c < 300; c++) begin
            if (!o0v && $urandom_range(0, 1) == 1) begin
                o0v = 1; o0r = 5'($urandom_range(0, 31)); o0d = $urandom;
            end
            if (!o1v && $urandom_range(0, 1) == 1) begin
                o1v = 1; o1r = 5'($urandom_range(0, 31)); o1d = $urandom;
            end
            h  = ($urandom_range(0, 3) == 0);
            g0 = o0v && (!o1v || !rr_m);
            g1 = o1v && (!o0v || rr_m);
            nf = (exp_q.size() < DEPTH);
            v  = mk(o0v, o0r, o0d, o1v, o1r, o1d, h, g0 && nf, g1 && nf);
            run_vec(v);
            if (v.e0) o0v = 0;
            if (v.e1) o1v = 0;
        end
        idle(DEPTH + 2);

        // Asynchronous reset with three entries queued and a write on the output stage
        run_vec(mk(1, 8, 32'h808, 0, 0, 0, 1, 1, 0));
        run_vec(mk(1, 9, 32'h909, 0, 0, 0, 1, 1, 0));
        run_vec(mk(1, 10, 32'hA0A, 0, 0, 0, 1, 1, 0));
        run_vec(mk(1, 11, 32'hB0B, 0, 0, 0, 0, 1, 0));
        s0_valid = 0; s0_reg = 0; s0_data = 0; hold = 0;
        chk("pre_reset_count", 64'(count), 64'(3));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_we", 64'(we), 64'(0));
        chk("async_reset_pend", 64'(pend), 64'(0));
        chk("async_reset_count", 64'(count), 64'(0));
        exp_q.delete();
        model_we = 1'b0;
        rr_m = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_vec(mk(1, 12, 32'h55, 0, 0, 0, 0, 1, 0));
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
